// File: rtl/tetris_key_cmd.sv
// tetris_key_cmd - turns PS/2 make/break events into Tetris commands with DAS/auto-repeat
// One-entry command register toward the game; sticky overflow flags dropped presses.
module tetris_key_cmd #(
    parameter int         DAS_DELAY  = 100_000_000,
    parameter int         ARR_PERIOD = 10_000_000,
    parameter logic [8:0] KEY_LEFT   = 9'h16B,
    parameter logic [8:0] KEY_RIGHT  = 9'h174,
    parameter logic [8:0] KEY_DOWN   = 9'h172,
    parameter logic [8:0] KEY_ROT    = 9'h175,
    parameter logic [8:0] KEY_DROP   = 9'h029,
    parameter logic [8:0] KEY_PAUSE  = 9'h04D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    input  logic         cmd_ready,
    output logic         cmd_valid,
    output logic [2:0]   cmd_code,
    output logic         overflow
);
    localparam int MAXP = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
    localparam int CW   = (MAXP > 2) ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] DAS_LOAD = CW'(DAS_DELAY - 1);
    localparam logic [CW-1:0] ARR_LOAD = CW'(ARR_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DAS, REPEAT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [8:0]    hkey, hkey_nx;
    logic [2:0]    press_code, ev_code;
    logic          press, rep_press, rep_fire, ev, xfer;

    function automatic logic [2:0] map_code(input logic [8:0] sc);
        if (sc == KEY_LEFT)       return 3'd1;
        else if (sc == KEY_RIGHT) return 3'd2;
        else if (sc == KEY_DOWN)  return 3'd3;
        else if (sc == KEY_ROT)   return 3'd4;
        else if (sc == KEY_DROP)  return 3'd5;
        else if (sc == KEY_PAUSE) return 3'd6;
        else                      return 3'd0;
    endfunction

    always_comb begin
        press_code = map_code(last_change);
        press      = key_valid & key_down[last_change] & (press_code != 3'd0);
        rep_press  = press & (press_code <= 3'd3);
        state_nx   = state;
        cnt_nx     = cnt;
        hkey_nx    = hkey;
        rep_fire   = 1'b0;
        if (rep_press) begin
            // last pressed repeatable key wins and restarts the delay
            state_nx = DAS;
            hkey_nx  = last_change;
            cnt_nx   = DAS_LOAD;
        end else if (state != IDLE) begin
            if (!key_down[hkey]) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (cnt == '0) begin
                // a concurrent non-repeatable press suppresses this repeat, timing carries on
                rep_fire = ~press;
                state_nx = REPEAT;
                cnt_nx   = ARR_LOAD;
            end else begin
                cnt_nx = cnt - 1'b1;
            end
        end
        ev      = press | rep_fire;
        ev_code = press ? press_code : map_code(hkey);
        xfer    = cmd_valid & cmd_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            hkey  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hkey  <= hkey_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 3'd0;
            overflow  <= 1'b0;
        end else begin
            if (ev && (!cmd_valid || xfer)) begin
                cmd_valid <= 1'b1;
                cmd_code  <= ev_code;
            end else if (xfer) begin
                cmd_valid <= 1'b0;
                cmd_code  <= 3'd0;
            end
            if (press && cmd_valid && !cmd_ready) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tetris_key_cmd.sv
// tb/tb_tetris_key_cmd.sv - directed self-checking bench for tetris_key_cmd
module tb_tetris_key_cmd;
    localparam logic [8:0] K_LEFT  = 9'h16B;
    localparam logic [8:0] K_RIGHT = 9'h174;
    localparam logic [8:0] K_ROT   = 9'h175;
    localparam logic [8:0] K_DROP  = 9'h029;
    localparam logic [8:0] K_PAUSE = 9'h04D;
    localparam logic [8:0] K_UNM   = 9'h01C;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [511:0] key_down = '0;
    logic [8:0]   last_change = '0;
    logic         key_valid = 1'b0;
    logic         cmd_ready = 1'b1;
    logic         cmd_valid;
    logic [2:0]   cmd_code;
    logic         overflow;

    int n_checks = 0;
    int n_fails  = 0;

    tetris_key_cmd #(.DAS_DELAY(8), .ARR_PERIOD(3)) dut (
        .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change),
        .key_valid(key_valid), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic strobe(input logic [8:0] code, input logic down);
        key_down[code] = down;
        last_change    = code;
        key_valid      = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] exp_code);
        chk({tag, "_valid"}, {8'd0, cmd_valid}, {8'd0, exp_code != 3'd0});
        chk({tag, "_code"}, {6'd0, cmd_code}, {6'd0, exp_code});
    endtask

    initial begin
        logic [2:0] e;
        #2;
        chk("rst_valid", {8'd0, cmd_valid}, 9'd0);
        chk("rst_code", {6'd0, cmd_code}, 9'd0);
        chk("rst_ovf", {8'd0, overflow}, 9'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // rotate: single command, never repeats
        strobe(K_ROT, 1'b1);
        step();
        for (int i = 1; i <= 12; i++) begin
            e = (i == 1) ? 3'd4 : 3'd0;
            chk_out("rot", e);
            step();
        end
        strobe(K_ROT, 1'b0);
        step();
        chk_out("rot_rel", 3'd0);

        // left held: t+1, t+9, t+12, t+15, t+18; release in cycle t+20
        strobe(K_LEFT, 1'b1);
        step();
        for (int i = 1; i <= 26; i++) begin
            if (i == 20) strobe(K_LEFT, 1'b0);
            e = (i == 1 || i == 9 || i == 12 || i == 15 || i == 18) ? 3'd1 : 3'd0;
            chk_out("left_rep", e);
            step();
        end

        // overflow with game stalled
        cmd_ready = 1'b0;
        strobe(K_DROP, 1'b1);
        step();
        chk_out("drop_load", 3'd5);
        chk("ovf_pre", {8'd0, overflow}, 9'd0);
        strobe(K_PAUSE, 1'b1);
        step();
        chk_out("drop_hold", 3'd5);
        chk("ovf_set", {8'd0, overflow}, 9'd1);
        step();
        chk_out("drop_hold2", 3'd5);
        cmd_ready = 1'b1;
        step();
        chk_out("drop_taken", 3'd0);
        strobe(K_DROP, 1'b0);
        step();
        strobe(K_PAUSE, 1'b0);
        step();
        chk_out("drop_rel", 3'd0);
        chk("ovf_sticky", {8'd0, overflow}, 9'd1);

        // unmapped code in idle
        strobe(K_UNM, 1'b1);
        step();
        chk_out("unm_press", 3'd0);
        strobe(K_UNM, 1'b0);
        step();
        chk_out("unm_rel", 3'd0);
        for (int i = 0; i < 10; i++) step();
        chk_out("unm_idle", 3'd0);

        // left held, right pressed at t+5; unmapped noise mid-DAS; left released at t+21
        strobe(K_LEFT, 1'b1);
        step();
        for (int i = 1; i <= 27; i++) begin
            if (i == 5)  strobe(K_RIGHT, 1'b1);
            if (i == 10) strobe(K_UNM, 1'b1);
            if (i == 11) strobe(K_UNM, 1'b0);
            if (i == 21) strobe(K_LEFT, 1'b0);
            if (i == 1) e = 3'd1;
            else if (i == 6 || i == 14 || i == 17 || i == 20 || i == 23 || i == 26) e = 3'd2;
            else e = 3'd0;
            chk_out("lr_rep", e);
            step();
        end

        // stall so a right repeat sits in the register, then reset mid-repeat
        cmd_ready = 1'b0;
        step();
        chk_out("pre_rst", 3'd2);
        rst = 1'b0;
        #1;
        chk_out("async_rst", 3'd0);
        chk("async_rst_ovf", {8'd0, overflow}, 9'd0);
        step();
        step();
        rst = 1'b1;
        cmd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("post_rst_valid", {8'd0, cmd_valid}, 9'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
